x25519_ladder_ctrl: RTL and testbench

X25519_LADDER_CTRL -- requirements
Module: x25519_ladder_ctrl

---
 rtl/x25519_pkg.sv | 26 ++
 rtl/x25519_cswap.sv | 29 ++
 rtl/x25519_ladder_ctrl.sv | 145 ++++++++++++++
 tb/tb_x25519_ladder_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/x25519_pkg.sv
// Shared types and constants for the X25519 Montgomery-ladder controller.
package x25519_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PREP,
    RUN,
    FINAL,
    DONE
  } state_t;

  localparam logic [255:0] P25519   = (256'd1 << 255) - 256'd19;
  localparam logic [255:0] A24      = 256'd121666;
  localparam int           STEP_LAT = 13;

  // Step-unit result capture points, counted from the first RUN cycle
  localparam logic [3:0] CAP_X2 = 4'd7;
  localparam logic [3:0] CAP_X3 = 4'd10;
  localparam logic [3:0] CAP_Z2 = 4'd11;
  localparam logic [3:0] CAP_Z3 = 4'd12;

  localparam logic [255:0] CLAMP_CLR = (256'd1 << 255) | 256'd7;
  localparam logic [255:0] CLAMP_SET = 256'd1 << 254;

endpackage

// File: rtl/x25519_cswap.sv
// Constant-time conditional swap of the (x2,x3) and (z2,z3) pairs.
module x25519_cswap
  import x25519_pkg::*;
(
  input  logic         swap,
  input  logic [255:0] x2,
  input  logic [255:0] x3,
  input  logic [255:0] z2,
  input  logic [255:0] z3,
  output logic [255:0] x2s,
  output logic [255:0] x3s,
  output logic [255:0] z2s,
  output logic [255:0] z3s
);

  logic [255:0] mask;
  logic [255:0] dx;
  logic [255:0] dz;

  // Every bit passes through the same XOR path whatever the swap bit is
  assign mask = {256{swap}};
  assign dx   = (x2 ^ x3) & mask;
  assign dz   = (z2 ^ z3) & mask;
  assign x2s  = x2 ^ dx;
  assign x3s  = x3 ^ dx;
  assign z2s  = z2 ^ dz;
  assign z3s  = z3 ^ dz;

endmodule

// File: rtl/x25519_ladder_ctrl.sv
// Montgomery-ladder sequencer driving an external 13-cycle step unit.
// Define X25519_CLAMP_EN to clamp the scalar as it is loaded.
module x25519_ladder_ctrl
  import x25519_pkg::*;
#(
  parameter int NBITS = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] scalar,
  input  logic [255:0] u_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] x_out,
  output logic [255:0] z_out,
  output logic         step_rst,
  output logic [255:0] step_x1,
  output logic [255:0] step_x2,
  output logic [255:0] step_z2,
  output logic [255:0] step_x3,
  output logic [255:0] step_z3,
  input  logic [255:0] step_x2n,
  input  logic [255:0] step_z2n,
  input  logic [255:0] step_x3n,
  input  logic [255:0] step_z3n
);

  state_t       state, state_nx;
  logic [255:0] k, x1, x2, z2, x3, z3;
  logic [255:0] op_x2, op_z2, op_x3, op_z3;
  logic [255:0] cx2, cx3, cz2, cz3;
  logic [7:0]   t;
  logic [3:0]   cnt;
  logic         swap;
  logic         cs_bit;

  assign cs_bit = (state == FINAL) ? swap : (swap ^ k[t]);

  x25519_cswap u_cswap (
    .swap (cs_bit),
    .x2   (x2),
    .x3   (x3),
    .z2   (z2),
    .z3   (z3),
    .x2s  (cx2),
    .x3s  (cx3),
    .z2s  (cz2),
    .z3s  (cz3)
  );

  // Operands come from a snapshot so captures mid-step cannot disturb them
  assign step_x1 = x1;
  assign step_x2 = op_x2;
  assign step_z2 = op_z2;
  assign step_x3 = op_x3;
  assign step_z3 = op_z3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    step_rst = (state == IDLE) || (state == PREP);
    case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD:  state_nx = PREP;
      PREP:  state_nx = RUN;
      RUN:   if (cnt == CAP_Z3) state_nx = (t == 8'd0) ? FINAL : PREP;
      FINAL: state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k     <= '0;
      x1    <= '0;
      x2    <= '0;
      z2    <= '0;
      x3    <= '0;
      z3    <= '0;
      op_x2 <= '0;
      op_z2 <= '0;
      op_x3 <= '0;
      op_z3 <= '0;
      x_out <= '0;
      z_out <= '0;
      t     <= '0;
      cnt   <= '0;
      swap  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
`ifdef X25519_CLAMP_EN
          k <= (scalar & ~CLAMP_CLR) | CLAMP_SET;
`else
          k <= scalar;
`endif
          x1   <= u_in & ~(256'd1 << 255);
          x3   <= u_in & ~(256'd1 << 255);
          x2   <= 256'd1;
          z2   <= '0;
          z3   <= 256'd1;
          swap <= 1'b0;
          t    <= 8'(NBITS - 1);
          cnt  <= '0;
        end
        PREP: begin
          x2    <= cx2;
          x3    <= cx3;
          z2    <= cz2;
          z3    <= cz3;
          op_x2 <= cx2;
          op_x3 <= cx3;
          op_z2 <= cz2;
          op_z3 <= cz3;
          swap  <= k[t];
          cnt   <= '0;
        end
        RUN: begin
          cnt <= cnt + 4'd1;
          if (cnt == CAP_X2) x2 <= step_x2n;
          if (cnt == CAP_X3) x3 <= step_x3n;
          if (cnt == CAP_Z2) z2 <= step_z2n;
          if (cnt == CAP_Z3) begin
            z3 <= step_z3n;
            if (t != 8'd0) t <= t - 8'd1;
          end
        end
        FINAL: begin
          x_out <= cx2;
          z_out <= cz2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_x25519_ladder_ctrl.sv
// Randomized bench for x25519_ladder_ctrl with a modular-arithmetic step-unit stub
// and an RFC 7748 ladder reference model.
module tb_x25519_ladder_ctrl;

  localparam int NBITS = 255;
  localparam logic [255:0] PM = (256'd1 << 255) - 256'd19;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] scalarIn, uIn;
  logic         busy, done, stepRst;
  logic [255:0] xOut, zOut;
  logic [255:0] sx1, sx2, sz2, sx3, sz3;
  logic [255:0] sx2n, sz2n, sx3n, sz3n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rstPulses = 0;
  int stepErr = 0;
  logic [255:0] prevX, prevZ;
  logic         prevValid = 1'b0;

  x25519_ladder_ctrl #(.NBITS(NBITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .scalar   (scalarIn),
    .u_in     (uIn),
    .busy     (busy),
    .done     (done),
    .x_out    (xOut),
    .z_out    (zOut),
    .step_rst (stepRst),
    .step_x1  (sx1),
    .step_x2  (sx2),
    .step_z2  (sz2),
    .step_x3  (sx3),
    .step_z3  (sz3),
    .step_x2n (sx2n),
    .step_z2n (sz2n),
    .step_x3n (sx3n),
    .step_z3n (sz3n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (stepRst && busy) rstPulses <= rstPulses + 1;

  function automatic logic [255:0] fred(input logic [255:0] a);
    return a % PM;
  endfunction

  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    return 256'(s % {1'b0, PM});
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, PM} - {1'b0, b};
    return 256'(s % {1'b0, PM});
  endfunction

  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] m;
    m = {256'b0, a} * {256'b0, b};
    return 256'(m % {256'b0, PM});
  endfunction

  // One RFC 7748 ladder step on reduced field elements
  function automatic void ladderStep(input logic [255:0] x1i, x2i, z2i, x3i, z3i,
                                     output logic [255:0] nx2, nz2, nx3, nz3);
    logic [255:0] x1, x2, z2, x3, z3, a, aa, b, bb, e, c, d, da, cb, s, df;
    x1 = fred(x1i); x2 = fred(x2i); z2 = fred(z2i); x3 = fred(x3i); z3 = fred(z3i);
    a  = fadd(x2, z2);  aa = fmul(a, a);
    b  = fsub(x2, z2);  bb = fmul(b, b);
    e  = fsub(aa, bb);
    c  = fadd(x3, z3);  d  = fsub(x3, z3);
    da = fmul(d, a);    cb = fmul(c, b);
    s  = fadd(da, cb);  df = fsub(da, cb);
    nx3 = fmul(s, s);
    nz3 = fmul(x1, fmul(df, df));
    nx2 = fmul(aa, bb);
    nz2 = fmul(e, fadd(aa, fmul(256'd121665, e)));
  endfunction

  function automatic logic [255:0] clampK(input logic [255:0] k);
    logic [255:0] r;
    r = k;
    r[2:0] = 3'b000;
    r[255] = 1'b0;
    r[254] = 1'b1;
    return r;
  endfunction

  function automatic logic [255:0] le2int(input logic [255:0] s);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = s[255 - 8*i -: 8];
    return r;
  endfunction

  function automatic void refX25519(input logic [255:0] kin, input logic [255:0] u,
                                    output logic [255:0] xr, output logic [255:0] zr);
    logic [255:0] k, x1, x2, z2, x3, z3, tmp;
    logic sw;
    k = kin;
`ifdef X25519_CLAMP_EN
    k = clampK(k);
`endif
    x1 = u;
    x1[255] = 1'b0;
    x2 = 256'd1; z2 = '0; x3 = x1; z3 = 256'd1; sw = 1'b0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      sw = sw ^ k[i];
      if (sw) begin
        tmp = x2; x2 = x3; x3 = tmp;
        tmp = z2; z2 = z3; z3 = tmp;
      end
      sw = k[i];
      ladderStep(x1, x2, z2, x3, z3, x2, z2, x3, z3);
    end
    if (sw) begin
      tmp = x2; x2 = x3; x3 = tmp;
      tmp = z2; z2 = z3; z3 = tmp;
    end
    xr = x2;
    zr = z2;
  endfunction

  // Step-unit stub: real results only at the capture offsets, tagged junk elsewhere
  logic [3:0]   off = '0;
  logic [255:0] rx2, rz2, rx3, rz3;
  logic [255:0] h1, h2, h3, h4, h5;

  always @(posedge clk) begin
    logic [255:0] n2, m2, n3, m3;
    if (stepRst) off <= '0;
    else if (off != 4'd15) off <= off + 4'd1;
    if (!stepRst && off == 4'd0) begin
      ladderStep(sx1, sx2, sz2, sx3, sz3, n2, m2, n3, m3);
      rx2 <= n2; rz2 <= m2; rx3 <= n3; rz3 <= m3;
      h1 <= sx1; h2 <= sx2; h3 <= sz2; h4 <= sx3; h5 <= sz3;
    end
    if (!stepRst && off == 4'd12 && busy &&
        {h1, h2, h3, h4, h5} != {sx1, sx2, sz2, sx3, sz3})
      stepErr <= stepErr + 1;
  end

  assign sx2n = (off == 4'd7)  ? rx2 : {4'h5, 244'h0, 4'h1, off};
  assign sx3n = (off == 4'd10) ? rx3 : {4'h5, 244'h0, 4'h2, off};
  assign sz2n = (off == 4'd11) ? rz2 : {4'h5, 244'h0, 4'h3, off};
  assign sz3n = (off == 4'd12) ? rz3 : {4'h5, 244'h0, 4'h4, off};

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [255:0] k, input logic [255:0] u,
                               input int pokeAt, input int abortAt);
    logic [255:0] ex, ez;
    int lat, ndone;
    logic busyAtDone, busyAfter;
    refX25519(k, u, ex, ez);
    scalarIn = k;
    uIn = u;
    lat = -1; ndone = 0; busyAtDone = 1'b0; busyAfter = 1'b1;
    @(negedge clk);
    rstPulses = 0;
    stepErr = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 3580; i++) begin
      @(negedge clk);
      start = (i == pokeAt);
      if (i == abortAt) begin
        rst = 1'b0;
        #1;
        checkOutput("abort_busy", 256'(busy), 256'd0);
        checkOutput("abort_done", 256'(done), 256'd0);
        checkOutput("abort_xout", xOut, 256'd0);
        checkOutput("abort_steprst", 256'(stepRst), 256'd1);
        start = 1'b0;
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          if (j == 2) rst = 1'b1;
          if (done) ndone++;
        end
        checkOutput("abort_nodone", 256'(ndone), 256'd0);
        prevX = '0; prevZ = '0; prevValid = 1'b1;
        return;
      end
      if (i == 1000 && prevValid) begin
        checkOutput("hold_x", xOut, prevX);
        checkOutput("hold_z", zOut, prevZ);
      end
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          busyAtDone = busy;
        end
      end
      if (lat >= 0 && i == lat + 1) busyAfter = busy;
    end
    start = 1'b0;
    checkOutput("latency", 256'(lat), 256'd3572);
    checkOutput("done_count", 256'(ndone), 256'd1);
    checkOutput("busy_at_done", 256'(busyAtDone), 256'd1);
    checkOutput("busy_after_done", 256'(busyAfter), 256'd0);
    checkOutput("x_out", xOut, ex);
    checkOutput("z_out", zOut, ez);
    checkOutput("steprst_pulses", 256'(rstPulses), 256'(NBITS));
    checkOutput("operand_stable", 256'(stepErr), 256'd0);
    prevX = ex; prevZ = ez; prevValid = 1'b1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [255:0] rk, ru, rout, kk;
    rst = 1'b0; start = 1'b0; scalarIn = '0; uIn = '0;
    #12;
    checkOutput("reset_busy", 256'(busy), 256'd0);
    checkOutput("reset_done", 256'(done), 256'd0);
    checkOutput("reset_steprst", 256'(stepRst), 256'd1);
    checkOutput("reset_xout", xOut, 256'd0);
    checkOutput("reset_zout", zOut, 256'd0);
    checkOutput("reset_op_x2", sx2, 256'd0);
    @(negedge clk);
    rst = 1'b1;

    // RFC 7748 section 5.2, first vector
    rk   = le2int(256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4);
    ru   = le2int(256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c);
    rout = le2int(256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552);
    applyStimulus(clampK(rk), ru, -1, -1);
    checkOutput("rfc_vector", xOut, fmul(rout, zOut));

    applyStimulus(256'd0, 256'd9, -1, -1);
`ifndef X25519_CLAMP_EN
    checkOutput("zero_k_x", xOut, 256'd1);
    checkOutput("zero_k_z", zOut, 256'd0);
`endif

    applyStimulus(rand256(), rand256(), 100, -1);

    kk = rand256();
    ru = rand256();
    applyStimulus(kk, ru, -1, 2000);
    applyStimulus(kk, ru, -1, -1);

    applyStimulus(rand256() | (256'd1 << 254), rand256(), -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
